// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared definitions for the pipeline stage register family.
//            It provides the occupancy encodings, which are also the stage
//            state encoding, and the default payload widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int IFID_W  = 64;

    // The stage state is the count of held entries. M fills before S, so
    // the pair of valid bits maps onto EMPTY, ONE and FULL.
    function automatic logic [1:0] occ_of(input logic m_valid, input logic s_valid);
        return {1'b0, m_valid} + {1'b0, s_valid};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg_if
// Purpose  : valid/ready/data handshake bundle between pipeline stages.
// Ports    : valid - producer offers data
//            ready - consumer accepts this cycle
//            data  - WIDTH-bit payload
//            The master modport is the producer side and the slave modport
//            is the consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int WIDTH = 64
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Adds a 0..3 increment each cycle and stops at all-ones. It
//            never wraps.
// Ports    : clk   - rising-edge clock
//            reset - synchronous active-high clear
//            inc   - increment for this cycle
//            count - current saturating count
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   inc,
    output logic [W-1:0] count
);

    localparam logic [W+1:0] c_max = {2'b00, {W{1'b1}}};

    logic [W-1:0] r_count;
    logic [W+1:0] w_sum;

    // The sum uses two spare bits, so an overflow is visible before the
    // result is clamped.
    assign w_sum = {2'b00, r_count} + {{W{1'b0}}, inc};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_sum > c_max) begin
            r_count <= '1;
        end else begin
            r_count <= w_sum[W-1:0];
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Parametrised pipeline stage register.
//            - It has a valid/ready handshake.
//            - It has an optional 2-entry skid buffer.
//            - A synchronous flush squashes held and incoming entries.
//            - A saturating counter counts the squashed entries.
// Ports    : clk, reset        - clock and synchronous active-high reset
//            in_if  (slave)    - upstream valid/ready/data
//            flush             - squash held entries and same-cycle input
//            out_if (master)   - downstream valid/ready/data
//            occupancy         - entries held (0..2)
//            drop_count        - saturating count of flushed entries
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = IFID_W,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    pipe_stage_reg_if.slave    in_if,
    input  logic               flush,
    pipe_stage_reg_if.master   out_if,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   drop_count
);

    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_data;
    logic             w_s_valid;
    logic [WIDTH-1:0] w_s_data;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_fire;
    logic [1:0]       w_state;
    logic [1:0]       w_drop_inc;

    assign w_fire   = r_m_valid & out_if.ready;
    assign w_accept = in_if.valid & w_in_ready & ~flush;
    assign w_state  = occ_of(r_m_valid, w_s_valid);

    generate
        if (SKID != 0) begin : g_skid
            logic             r_s_valid;
            logic [WIDTH-1:0] r_s_data;

            // S catches the word that arrives while M is stalled. In_ready
            // comes only from S, so back-pressure is fully registered.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s_valid <= 1'b0;
                    r_s_data  <= '0;
                end else if (flush) begin
                    r_s_valid <= 1'b0;
                end else if (w_state == OCC_ONE && w_accept && !w_fire) begin
                    r_s_valid <= 1'b1;
                    r_s_data  <= in_if.data;
                end else if (w_state == OCC_FULL && w_fire) begin
                    r_s_valid <= 1'b0;
                end
            end

            assign w_s_valid  = r_s_valid;
            assign w_s_data   = r_s_data;
            assign w_in_ready = ~r_s_valid;
        end else begin : g_no_skid
            // A single register refills in the same cycle it drains, so
            // ready depends combinationally on the downstream ready.
            assign w_s_valid  = 1'b0;
            assign w_s_data   = '0;
            assign w_in_ready = ~r_m_valid | out_if.ready;
        end
    endgenerate

    // Main register. The stage is empty when M is invalid, and S is valid
    // only when M is also valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
        end else begin
            case (w_state)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= in_if.data;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && w_fire) begin
                        r_m_data <= in_if.data;
                    end else if (w_fire) begin
                        r_m_valid <= 1'b0;
                    end
                end
                OCC_FULL: begin
                    if (w_fire) begin
                        r_m_data <= w_s_data;
                    end
                end
                default: begin
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    // An entry that fires in the flush cycle has already been delivered, so
    // it does not count as dropped. Input counts only if it was offered while
    // ready was high.
    assign w_drop_inc = flush ? ({1'b0, r_m_valid & ~w_fire}
                               + {1'b0, w_s_valid}
                               + {1'b0, in_if.valid & w_in_ready})
                              : 2'd0;

    sat_counter #(
        .W (CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_drop_inc),
        .count (drop_count)
    );

    assign in_if.ready  = w_in_ready;
    assign out_if.valid = r_m_valid;
    assign out_if.data  = r_m_data;
    assign occupancy    = w_state;

    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (r_m_valid && !out_if.ready && !flush) |=> (r_m_valid && $stable(r_m_data)));

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg. It drives three
//            instances from one stimulus stream:
//              dut0 - SKID=1, CNT_W=16
//              dut1 - SKID=0, CNT_W=16
//              dut2 - SKID=1, CNT_W=4 (reaches saturation quickly)
//            A scoreboard per instance holds the words expected downstream.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         flush;
    logic         out_ready;
    logic [W-1:0] in_data;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.WIDTH(W)) a_in ();
    pipe_stage_reg_if #(.WIDTH(W)) a_out ();
    pipe_stage_reg_if #(.WIDTH(W)) b_in ();
    pipe_stage_reg_if #(.WIDTH(W)) b_out ();
    pipe_stage_reg_if #(.WIDTH(W)) c_in ();
    pipe_stage_reg_if #(.WIDTH(W)) c_out ();

    assign a_in.valid  = in_valid;
    assign a_in.data   = in_data;
    assign a_out.ready = out_ready;
    assign b_in.valid  = in_valid;
    assign b_in.data   = in_data;
    assign b_out.ready = out_ready;
    assign c_in.valid  = in_valid;
    assign c_in.data   = in_data;
    assign c_out.ready = out_ready;

    logic [1:0]  occ_a, occ_b, occ_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .in_if(a_in), .flush(flush),
        .out_if(a_out), .occupancy(occ_a), .drop_count(cnt_a));
    pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .in_if(b_in), .flush(flush),
        .out_if(b_out), .occupancy(occ_b), .drop_count(cnt_b));
    pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .in_if(c_in), .flush(flush),
        .out_if(c_out), .occupancy(occ_c), .drop_count(cnt_c));

    logic         d_rdy  [3];
    logic         d_vld  [3];
    logic [W-1:0] d_data [3];
    logic [1:0]   d_occ  [3];
    logic [15:0]  d_cnt  [3];

    assign d_rdy[0]  = a_in.ready;   assign d_rdy[1]  = b_in.ready;   assign d_rdy[2]  = c_in.ready;
    assign d_vld[0]  = a_out.valid;  assign d_vld[1]  = b_out.valid;  assign d_vld[2]  = c_out.valid;
    assign d_data[0] = a_out.data;   assign d_data[1] = b_out.data;   assign d_data[2] = c_out.data;
    assign d_occ[0]  = occ_a;        assign d_occ[1]  = occ_b;        assign d_occ[2]  = occ_c;
    assign d_cnt[0]  = cnt_a;        assign d_cnt[1]  = cnt_b;        assign d_cnt[2]  = {12'd0, cnt_c};

    // Scoreboard state per instance. The queue holds at most two entries.
    int           m_size [3];
    logic [W-1:0] m_q    [3][2];
    int           m_cnt  [3];
    int           m_skid [3] = '{1, 0, 1};
    int           m_max  [3] = '{65535, 65535, 15};

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         f;
        logic         r;
        logic [1:0]   occ;   // dut0 occupancy seen during this vector
        logic [15:0]  cnt;   // dut0 drop_count seen during this vector
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_size[k] = 0;
            m_cnt[k]  = 0;
        end
    endtask

    // The task applies one cycle of stimulus and checks every instance at the
    // negedge. It then advances the scoreboards over the next rising edge.
    task automatic tick(input logic v, input logic [W-1:0] d, input logic f, input logic r,
                        input logic use_tbl, input logic [1:0] t_occ, input logic [15:0] t_cnt);
        logic exp_rdy [3];
        logic fire;
        logic acc;
        int   drop;
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        @(negedge clk);
        if (use_tbl) begin
            chk("tbl occupancy", W'(d_occ[0]), W'(t_occ));
            chk("tbl drop_count", W'(d_cnt[0]), W'(t_cnt));
        end
        for (int k = 0; k < 3; k++) begin
            exp_rdy[k] = (m_skid[k] != 0) ? (m_size[k] < 2) : (m_size[k] == 0 || r);
            chk($sformatf("dut%0d in_ready", k), W'(d_rdy[k]), W'(exp_rdy[k]));
            chk($sformatf("dut%0d out_valid", k), W'(d_vld[k]), W'(m_size[k] > 0));
            chk($sformatf("dut%0d occupancy", k), W'(d_occ[k]), W'(m_size[k]));
            chk($sformatf("dut%0d drop_count", k), W'(d_cnt[k]), W'(m_cnt[k]));
            if (m_size[k] > 0)
                chk($sformatf("dut%0d out_data", k), d_data[k], m_q[k][0]);
        end
        for (int k = 0; k < 3; k++) begin
            fire = (m_size[k] > 0) && r;
            acc  = v && exp_rdy[k] && !f;
            if (f) begin
                drop = ((m_size[k] > 0 && !fire) ? 1 : 0) + ((m_size[k] == 2) ? 1 : 0)
                     + ((v && exp_rdy[k]) ? 1 : 0);
                m_cnt[k]  = (m_cnt[k] + drop > m_max[k]) ? m_max[k] : m_cnt[k] + drop;
                m_size[k] = 0;
            end else begin
                if (fire) begin
                    m_q[k][0] = m_q[k][1];
                    m_size[k]--;
                end
                if (acc) begin
                    m_q[k][m_size[k]] = d;
                    m_size[k]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic f, input logic r);
        tick(v, d, f, r, 1'b0, 2'd0, 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 64'h1000_0004, 1'b0, 1'b1, 2'd0, 16'd0};
        vecs[1]  = '{1'b1, 64'h1000_0008, 1'b0, 1'b1, 2'd1, 16'd0};
        vecs[2]  = '{1'b1, 64'h1000_000C, 1'b0, 1'b1, 2'd1, 16'd0};
        vecs[3]  = '{1'b0, 64'h0,         1'b0, 1'b1, 2'd1, 16'd0};
        vecs[4]  = '{1'b1, 64'hAAAA,      1'b0, 1'b0, 2'd0, 16'd0};
        vecs[5]  = '{1'b1, 64'hBBBB,      1'b0, 1'b0, 2'd1, 16'd0};
        vecs[6]  = '{1'b0, 64'h0,         1'b0, 1'b0, 2'd2, 16'd0};
        vecs[7]  = '{1'b0, 64'h0,         1'b0, 1'b1, 2'd2, 16'd0};
        vecs[8]  = '{1'b0, 64'h0,         1'b0, 1'b1, 2'd1, 16'd0};
        vecs[9]  = '{1'b0, 64'h0,         1'b0, 1'b1, 2'd0, 16'd0};
        vecs[10] = '{1'b1, 64'hC1,        1'b0, 1'b0, 2'd0, 16'd0};
        vecs[11] = '{1'b1, 64'hC2,        1'b0, 1'b0, 2'd1, 16'd0};
        vecs[12] = '{1'b1, 64'hC3,        1'b1, 1'b0, 2'd2, 16'd0};
        vecs[13] = '{1'b0, 64'h0,         1'b0, 1'b0, 2'd0, 16'd2};
        vecs[14] = '{1'b1, 64'hD1,        1'b0, 1'b0, 2'd0, 16'd2};
        vecs[15] = '{1'b1, 64'hD2,        1'b1, 1'b1, 2'd1, 16'd2};
        vecs[16] = '{1'b0, 64'h0,         1'b0, 1'b1, 2'd0, 16'd3};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("dut%0d reset out_data", k), d_data[k], '0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++)
            tick(vecs[i].v, vecs[i].d, vecs[i].f, vecs[i].r, 1'b1, vecs[i].occ, vecs[i].cnt);

        // Each pass fills the skid instances and flushes two entries. This
        // pushes dut2 (CNT_W=4) past all-ones and checks that it holds there.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 64'hE000 + 64'(i), 1'b0, 1'b0);
            step(1'b1, 64'hF000 + 64'(i), 1'b0, 1'b0);
            step(1'b1, 64'h9000 + 64'(i), 1'b1, 1'b0);
        end
        step(1'b0, 64'h0, 1'b0, 1'b1);

        // For SKID=0, in_ready must follow out_ready while M is valid.
        step(1'b1, 64'h5101, 1'b0, 1'b0);
        step(1'b1, 64'h5102, 1'b0, 1'b0);
        step(1'b1, 64'h5103, 1'b0, 1'b1);
        step(1'b1, 64'h5104, 1'b0, 1'b0);
        step(1'b1, 64'h5105, 1'b0, 1'b1);
        step(1'b0, 64'h0,    1'b0, 1'b1);
        step(1'b0, 64'h0,    1'b0, 1'b1);

        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), {$urandom, $urandom},
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; successor to the fixed IF/ID latch. Carries an arbitrary-width bundle, e.g. {instruction, PC+4} = 64 bits, between pipeline stages.
- Adds a valid/ready handshake, an optional 2-entry skid buffer for registered back-pressure, synchronous flush for branch and jump squash, and a saturating count of squashed entries.
- Instantiated once per stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- WIDTH, 64, payload width in bits.
- SKID, 1. Value 1 gives a 2-entry skid buffer with registered in_ready. Value 0 gives a single register with combinational in_ready.
- CNT_W, 16, width of drop_count.

Ports:
- clk  input  1  stage clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- flush  input  1  squash all held entries and any same-cycle input.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  payload to next stage.
- occupancy  output  2  number of valid entries held, 0 to 2.
- drop_count  output  CNT_W  saturating count of entries discarded by flush.

Behaviour:
- Terms:
  - accept = in_valid & in_ready & !flush.
  - fire = out_valid & out_ready.
- Storage: main register M (data, valid); skid register S (data, valid), present only when SKID=1.
- Outputs from state:
  - out_valid = M.valid; out_data = M.data.
  - occupancy = M.valid + S.valid.
- Reset, synchronous when reset=1 at an edge; reset has priority over flush:
  - M.valid = S.valid = 0; M.data = S.data = 0; drop_count = 0.
  - Resulting outputs: out_valid = 0, out_data = 0, occupancy = 0.
  - With SKID=1, in_ready = 1 in the cycle after reset.
- in_ready:
  - SKID=1: in_ready = !S.valid (registered state only; no combinational path from out_ready).
  - SKID=0: in_ready = !M.valid | out_ready.
- State machine for SKID=1, encoded as occupancy:
  - EMPTY: accept -> ONE, M <= in_data.
  - ONE, accept & fire -> ONE, M <= in_data.
  - ONE, accept & !fire -> FULL, S <= in_data.
  - ONE, !accept & fire -> EMPTY.
  - ONE, neither -> hold.
  - FULL: in_ready = 0. fire -> ONE, M <= S.data, S.valid <= 0. Otherwise hold.
- SKID=0: FULL is unreachable. accept loads M; fire & !accept -> EMPTY.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput is 1 per cycle when out_ready is held high.
- Stability: while out_valid & !out_ready, out_data and out_valid hold unchanged (checked by assertion).
- Flush, at an edge with flush=1 and reset=0:
  - Next state is EMPTY; same-cycle in_data is discarded.
  - A same-cycle fire is a completed transfer and is not counted as dropped.
  - drop_count += (M.valid & !fire) + S.valid + (in_valid & in_ready).
  - drop_count saturates at 2^CNT_W-1; it never wraps.
- Data registers are not cleared by flush. out_data is don't-care while out_valid = 0.
- All arithmetic is unsigned; the drop increment is 0 to 3, zero-extended to CNT_W.

Decomposition:
- Shared package pipe_pkg holds:
  - localparams OCC_EMPTY = 2'd0, OCC_ONE = 2'd1, OCC_FULL = 2'd2.
  - Default widths: INSTR_W = 32, PC_W = 32, IFID_W = 64.
- One sub-module, sat_counter (parameter W; inputs clk, reset, inc[1:0]; output count), used for drop_count.

Test Plan:
- Reset held 2 cycles, then released -> out_valid = 0, occupancy = 0, drop_count = 0, in_ready = 1 on the next cycle.
- SKID=1, out_ready = 1, stream 0x1000_0004, 0x1000_0008, 0x1000_000C on consecutive cycles -> each appears on out_data exactly 1 cycle after accept, with no bubbles.
- SKID=1, out_ready = 0, push A = 0xAAAA and B = 0xBBBB -> occupancy = 2 and in_ready = 0. Set out_ready = 1 -> A then B on consecutive cycles, then occupancy = 0.
- FULL state plus flush = 1 with in_valid = 1 and out_ready = 0 -> next cycle occupancy = 0 and drop_count = 2 (input not counted because in_ready = 0).
- ONE state, flush with fire and accept-eligible input in the same cycle -> drop_count += 1 (input only), and the fired entry is observed downstream.
- Force drop_count to 0xFFFE via CNT_W = 16 stress, then flush with 2 entries -> drop_count = 0xFFFF and stays there. SKID=0 regression: in_ready follows out_ready whenever M.valid = 1.
